bram_tile_reader: RTL and testbench
===================================

// Module: bram_tile_reader
// PURPOSE
//  Read side of the 16-line strip BRAM filled by Bram_interface. Strip is stored row-major (addr = row*IMG_WIDTH + col).
//  On iStart (driven by the writer's oDone_sig), reads the strip out in tile order: tile 0..N-1 left to right, each tile in raster order.
//  Pixels leave on a valid/ready stream. Internal credit FIFO absorbs BRAM read latency under backpressure.
// PARAMETERS
//  RAM_WIDTH    8      pixel/data width
//  RAM_DEPTH    10240  strip buffer depth; must equal IMG_WIDTH*TILE_HEIGHT
//  RD_LATENCY   2      BRAM read latency in cycles (2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY)
//  IMG_WIDTH    640    pixels per line; multiple of TILE_WIDTH
//  TILE_WIDTH   16     tile columns
//  TILE_HEIGHT  16     tile rows = lines per strip
//  FIFO_DEPTH   4      output FIFO entries; power of 2, >= RD_LATENCY+2
// PORTS
//  iClk      in   1                   clock
//  iRst      in   1                   synchronous reset, active-low
//  iStart    in   1                   1-cycle pulse: strip is ready in BRAM
//  oRdEn     out  1                   BRAM read enable
//  oRdAddr   out  $clog2(RAM_DEPTH)   BRAM read address
//  iRdData   in   RAM_WIDTH           BRAM read data, valid RD_LATENCY cycles after oRdEn
//  oData     out  RAM_WIDTH           stream pixel
//  oValid    out  1                   oData valid
//  iReady    in   1                   downstream accepts; a beat transfers when oValid & iReady
//  oBusy     out  1                   high from the cycle after accepted iStart until oDone
//  oDone     out  1                   1-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset (iRst=0 at posedge): FSM=IDLE; oRdEn, oValid, oBusy and oDone = 0; oRdAddr = 0. FIFO, counters and in-flight tracking are cleared.
//  FSM states: IDLE -> READ on iStart. READ -> DRAIN in the cycle after the last address is issued.
//   DRAIN -> DONE when FIFO is empty and in-flight = 0. DONE -> IDLE after one cycle; oDone=1 only in DONE.
//  iStart outside IDLE is ignored (no restart, no queueing).
//  Counters: col c (0..TILE_WIDTH-1), row r (0..TILE_HEIGHT-1), tile t (0..IMG_WIDTH/TILE_WIDTH-1).
//   c wraps and increments r; r wraps and increments t.
//   oRdAddr = r*IMG_WIDTH + t*TILE_WIDTH + c. Computed with shift/add, registered; no multiplier in the path.
//  Issue rule: in READ, oRdEn=1 iff (fifo_count + inflight) < FIFO_DEPTH, using registered values. Counters advance only on an issued read.
//  Read data is captured into the FIFO exactly RD_LATENCY cycles after its oRdEn (valid-bit shift register).
//   The FIFO can never overflow; an overflow is a design error (assertion).
//  oValid = FIFO not empty; oData = FIFO head. Pop on oValid & iReady. Push and pop in the same cycle keep the count unchanged.
//  Latency: iStart sampled at edge k -> first oRdEn in cycle k+1 -> first oValid in cycle k+2+RD_LATENCY.
//  Throughput: with iReady held at 1, one beat per cycle sustained; total beats = RAM_DEPTH.
//  oData is held stable while oValid & !iReady.
//  Reset mid-strip: everything is cleared next edge. In-flight BRAM data is discarded. The next iStart restarts at addr 0.
// CONFIGURATION
//  BRAM_TILE_READER_MARKERS_EN defined: adds outputs oTileFirst and oTileLast (1 bit each).
//   Both are carried through the FIFO alongside the data and qualified by oValid.
//   oTileFirst=1 on (r,c)=(0,0) of each tile. oTileLast=1 on (TILE_HEIGHT-1,TILE_WIDTH-1). Reset value 0.
//  Not defined: ports and FIFO sideband bits are absent; data path is unchanged.
// TESTING
//  T1 reset: hold iRst=0 3 cycles with random iStart/iReady -> oValid=oRdEn=oBusy=oDone=0, oRdAddr=0.
//  T2 full strip, iReady=1, BRAM model mem[a]=a[7:0]:
//     beats 0..15 = addr 0..15, beat 16 = addr 640, beat 256 = addr 16.
//     10240 beats, no gaps after the first; first oValid at k+4; oDone pulses once.
//  T3 iReady random 50%: same address sequence as T2, no loss or duplicates.
//     fifo_count+inflight <= 4 always; oData stable while stalled.
//  T4 iStart pulses at beat 100 and during the DONE cycle -> ignored. Exactly 10240 beats, one oDone.
//  T5 iRst=0 at beat 1000 -> next cycle oValid=0, oBusy=0. New iStart -> first beat is addr 0, 10240 beats.
//  T6 MARKERS_EN, RD_LATENCY=1: oTileFirst at beats 0,256,..,9984; oTileLast at beats 255,511,..,10239.

Source files
------------

// File: rtl/bram_tile_reader.sv
// rtl/bram_tile_reader.sv - tile-order read-out of a 16-line strip BRAM onto a valid/ready pixel stream
//
// Reads the strip written by Bram_interface (row-major, addr = row*IMG_WIDTH + col)
// and emits it tile by tile: tiles left to right, each tile in raster order.
// Reads are issued only when the output FIFO is guaranteed to have room for the
// data once it returns, so BRAM latency is absorbed under downstream backpressure.
//
// Ports:
//   iClk        clock
//   iRst        synchronous reset, active-low
//   iStart      1-cycle pulse: strip is ready in BRAM (ignored unless idle)
//   oRdEn       BRAM read enable
//   oRdAddr     BRAM read address
//   iRdData     BRAM read data, valid RD_LATENCY cycles after oRdEn
//   oData       stream pixel (FIFO head)
//   oValid      oData valid (FIFO not empty)
//   iReady      downstream accepts; a beat transfers on oValid & iReady
//   oBusy       high from the cycle after an accepted iStart through the oDone cycle
//   oDone       1-cycle pulse after the last beat has been accepted
//   oTileFirst  (BRAM_TILE_READER_MARKERS_EN only) beat is pixel (0,0) of a tile
//   oTileLast   (BRAM_TILE_READER_MARKERS_EN only) beat is the last pixel of a tile
//
// Build option: define BRAM_TILE_READER_MARKERS_EN to add the tile marker outputs.

module bram_tile_reader #(
  parameter int RAM_WIDTH   = 8,
  parameter int RAM_DEPTH   = 10240,
  parameter int RD_LATENCY  = 2,
  parameter int IMG_WIDTH   = 640,
  parameter int TILE_WIDTH  = 16,
  parameter int TILE_HEIGHT = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iStart,
  output logic                         oRdEn,
  output logic [$clog2(RAM_DEPTH)-1:0] oRdAddr,
  input  logic [RAM_WIDTH-1:0]         iRdData,
  output logic [RAM_WIDTH-1:0]         oData,
  output logic                         oValid,
  input  logic                         iReady,
  output logic                         oBusy,
  output logic                         oDone
`ifdef BRAM_TILE_READER_MARKERS_EN
  ,
  output logic                         oTileFirst,
  output logic                         oTileLast
`endif
);

  localparam int ADDR_W    = $clog2(RAM_DEPTH);
  localparam int NUM_TILES = IMG_WIDTH / TILE_WIDTH;
  localparam int COL_W     = (TILE_WIDTH  > 1) ? $clog2(TILE_WIDTH)  : 1;
  localparam int ROW_W     = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
  localparam int TILE_W    = (NUM_TILES   > 1) ? $clog2(NUM_TILES)   : 1;
  localparam int PTR_W     = (FIFO_DEPTH  > 1) ? $clog2(FIFO_DEPTH)  : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(TILE_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(TILE_HEIGHT - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);
  // Jump from the last column of one tile row to the first column of the next row.
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_WIDTH - TILE_WIDTH + 1);
  localparam logic [ADDR_W-1:0] TILE_STEP = ADDR_W'(TILE_WIDTH);
  localparam logic [CNT_W:0]    OCC_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t stateNext;

  // Scan position and the matching address, kept incrementally.
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [TILE_W-1:0] tile;
  logic [ADDR_W-1:0] addrReg;
  logic [ADDR_W-1:0] tileBase;

  // Output FIFO and read tracking.
  logic [RAM_WIDTH-1:0]  dataMem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic [CNT_W-1:0]      fifoCount;
  logic [CNT_W-1:0]      inflight;
  logic [RD_LATENCY-1:0] vldSr;
  logic [CNT_W:0]        occupancy;

  logic lastCol;
  logic lastRow;
  logic lastTile;
  logic lastAddr;
  logic issue;
  logic push;
  logic pop;

  always_comb begin
    lastCol   = (col == COL_LAST);
    lastRow   = (row == ROW_LAST);
    lastTile  = (tile == TILE_LAST);
    lastAddr  = lastCol && lastRow && lastTile;
    // Entries already in the FIFO plus reads still in the BRAM pipe: a new read is
    // issued only if its data is guaranteed a slot when it lands.
    occupancy = {1'b0, fifoCount} + {1'b0, inflight};
    issue     = (state == READ) && (occupancy < OCC_LIMIT);
    push      = vldSr[RD_LATENCY-1];
    pop       = (fifoCount != '0) && iReady;
  end

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and outputs
  always_comb begin
    stateNext = state;
    oRdEn     = issue;
    oRdAddr   = addrReg;
    oBusy     = (state != IDLE);
    oDone     = (state == DONE);
    oValid    = (fifoCount != '0);
    oData     = dataMem[rdPtr];
    case (state)
      IDLE:    if (iStart) stateNext = READ;
      READ:    if (issue && lastAddr) stateNext = DRAIN;
      DRAIN:   if ((fifoCount == '0) && (inflight == '0)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Tile-order address generator: no multiplier, the row and tile strides are
  // applied as additions when the column (and row) counters wrap.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      col      <= '0;
      row      <= '0;
      tile     <= '0;
      addrReg  <= '0;
      tileBase <= '0;
    end else if ((state == IDLE) && iStart) begin
      col      <= '0;
      row      <= '0;
      tile     <= '0;
      addrReg  <= '0;
      tileBase <= '0;
    end else if (issue) begin
      if (!lastCol) begin
        col     <= col + 1'b1;
        addrReg <= addrReg + 1'b1;
      end else begin
        col <= '0;
        if (!lastRow) begin
          row     <= row + 1'b1;
          addrReg <= addrReg + ROW_STEP;
        end else begin
          row      <= '0;
          tile     <= lastTile ? '0 : tile + 1'b1;
          tileBase <= tileBase + TILE_STEP;
          addrReg  <= tileBase + TILE_STEP;
        end
      end
    end
  end

  // One valid bit per BRAM pipeline stage; the bit leaving the last stage marks the
  // cycle in which iRdData belongs to an issued read. Clearing it on reset drops
  // any reads still in flight.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      vldSr <= '0;
    end else begin
      vldSr[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vldSr[i] <= vldSr[i-1];
      end
    end
  end

  // FIFO pointers, fill count and in-flight count
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      inflight  <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
      case ({issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  // The head is never the write target while valid, so oData holds during stalls.
  always_ff @(posedge iClk) begin
    if (push) dataMem[wrPtr] <= iRdData;
  end

  // The issue rule bounds occupancy by FIFO_DEPTH, so a push into a full FIFO
  // can only mean the tracking logic is broken.
  always_ff @(posedge iClk) begin
    if (iRst && push) begin
      assert (fifoCount < CNT_FULL);
    end
  end

`ifdef BRAM_TILE_READER_MARKERS_EN
  // Tile markers are computed at issue time from the scan counters and ride the
  // BRAM pipe and the FIFO next to the pixel they describe.
  logic [1:0] markSr  [RD_LATENCY];
  logic [1:0] markMem [FIFO_DEPTH];

  always_ff @(posedge iClk) begin
    markSr[0] <= {(row == '0) && (col == '0), lastRow && lastCol};
    for (int i = 1; i < RD_LATENCY; i++) begin
      markSr[i] <= markSr[i-1];
    end
    if (push) markMem[wrPtr] <= markSr[RD_LATENCY-1];
  end

  always_comb begin
    oTileFirst = oValid && markMem[rdPtr][1];
    oTileLast  = oValid && markMem[rdPtr][0];
  end
`endif

endmodule

// File: tb/tb_bram_tile_reader.sv
// tb/tb_bram_tile_reader.sv - randomized self-checking bench for bram_tile_reader

module tb_bram_tile_reader;

  localparam int RAM_WIDTH   = 8;
  localparam int RAM_DEPTH   = 10240;
  localparam int IMG_WIDTH   = 640;
  localparam int TILE_WIDTH  = 16;
  localparam int TILE_HEIGHT = 16;
  localparam int FIFO_DEPTH  = 4;
`ifdef BRAM_TILE_READER_MARKERS_EN
  localparam int RD_LATENCY  = 1;
`else
  localparam int RD_LATENCY  = 2;
`endif
  localparam int ADDR_W      = $clog2(RAM_DEPTH);
  localparam int TILE_PIX    = TILE_WIDTH * TILE_HEIGHT;
  localparam int MAX_CYCLES  = 30000;

  logic                 clk = 1'b0;
  logic                 iRst;
  logic                 iStart;
  logic                 oRdEn;
  logic [ADDR_W-1:0]    oRdAddr;
  logic [RAM_WIDTH-1:0] iRdData;
  logic [RAM_WIDTH-1:0] oData;
  logic                 oValid;
  logic                 iReady;
  logic                 oBusy;
  logic                 oDone;
`ifdef BRAM_TILE_READER_MARKERS_EN
  logic                 oTileFirst;
  logic                 oTileLast;
`endif

  always #5 clk = ~clk;

  bram_tile_reader #(
    .RAM_WIDTH  (RAM_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH),
    .RD_LATENCY (RD_LATENCY),
    .IMG_WIDTH  (IMG_WIDTH),
    .TILE_WIDTH (TILE_WIDTH),
    .TILE_HEIGHT(TILE_HEIGHT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .iClk      (clk),
    .iRst      (iRst),
    .iStart    (iStart),
    .oRdEn     (oRdEn),
    .oRdAddr   (oRdAddr),
    .iRdData   (iRdData),
    .oData     (oData),
    .oValid    (oValid),
    .iReady    (iReady),
    .oBusy     (oBusy),
    .oDone     (oDone)
`ifdef BRAM_TILE_READER_MARKERS_EN
    ,
    .oTileFirst(oTileFirst),
    .oTileLast (oTileLast)
`endif
  );

  // BRAM model: mem[a] = a[7:0], data appears RD_LATENCY cycles after oRdEn.
  logic [RAM_WIDTH-1:0] rdPipe [RD_LATENCY];
  always @(posedge clk) begin
    rdPipe[0] <= oRdEn ? oRdAddr[RAM_WIDTH-1:0] : 8'hA5;
    for (int i = 1; i < RD_LATENCY; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign iRdData = rdPipe[RD_LATENCY-1];

  int    total = 0;
  int    bad   = 0;
  string curTest = "";

  task automatic checkVal(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0d expected %0d", curTest, tag, got, exp);
    end
  endtask

  // Address of the idx-th pixel in tile order, straight from the strip geometry.
  function automatic int expAddr(input int idx);
    int t = idx / TILE_PIX;
    int w = idx % TILE_PIX;
    return (w / TILE_WIDTH) * IMG_WIDTH + t * TILE_WIDTH + (w % TILE_WIDTH);
  endfunction

  task automatic runStrip(input string name, input int readyPct, input bit poke, input int abortAt);
    int   issued = 0;
    int   beats = 0;
    int   gaps = 0;
    int   firstValid = -1;
    int   cyc;
    bit   prevStall = 0;
    bit   pokedMid = 0;
    bit   ended = 0;
    bit   aborted = 0;
    logic [RAM_WIDTH-1:0] prevData = '0;
    curTest = name;
    @(negedge clk);
    iStart = 1'b1;
    iReady = 1'b0;
    @(negedge clk);
    iStart = 1'b0;
    cyc = 1;
    checkVal("busy_start", oBusy, 1);
    while (!ended && !aborted && cyc < MAX_CYCLES) begin
      iStart = 1'b0;
      iReady = ($urandom_range(99) < readyPct);
      if (poke && !pokedMid && beats == 100) begin
        iStart = 1'b1;
        pokedMid = 1;
      end
      if (abortAt >= 0 && beats == abortAt) begin
        aborted = 1;
      end else begin
        if (oRdEn) begin
          checkVal("addr", oRdAddr, expAddr(issued));
          issued++;
          checkVal("occupancy_ok", (issued - beats) <= FIFO_DEPTH, 1);
        end
        if (prevStall) begin
          checkVal("hold_valid", oValid, 1);
          checkVal("hold_data", oData, prevData);
        end
        if (oValid && firstValid < 0) firstValid = cyc;
        if (firstValid >= 0 && !oValid && beats < RAM_DEPTH) gaps++;
        if (oValid && iReady) begin
          checkVal("data", oData, expAddr(beats) & ((1 << RAM_WIDTH) - 1));
`ifdef BRAM_TILE_READER_MARKERS_EN
          checkVal("tile_first", oTileFirst, (beats % TILE_PIX) == 0);
          checkVal("tile_last", oTileLast, (beats % TILE_PIX) == TILE_PIX - 1);
`endif
          beats++;
        end
        prevStall = oValid && !iReady;
        prevData  = oData;
        if (oDone) begin
          checkVal("done_beats", beats, RAM_DEPTH);
          if (poke) iStart = 1'b1;
          ended = 1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    iStart = 1'b0;
    if (aborted) begin
      iRst = 1'b0;
      @(negedge clk);
      iRst = 1'b1;
      checkVal("abort_valid", oValid, 0);
      checkVal("abort_busy", oBusy, 0);
      checkVal("abort_rden", oRdEn, 0);
      checkVal("abort_done", oDone, 0);
    end else begin
      checkVal("finished", ended, 1);
      checkVal("issued", issued, RAM_DEPTH);
      checkVal("beats", beats, RAM_DEPTH);
      if (readyPct >= 100) begin
        checkVal("first_valid_cycle", firstValid, 2 + RD_LATENCY);
        checkVal("gaps", gaps, 0);
      end
      // After DONE the block must be idle: no second oDone, no restart.
      for (int i = 0; i < 4; i++) begin
        checkVal("idle_done", oDone, 0);
        checkVal("idle_busy", oBusy, 0);
        checkVal("idle_rden", oRdEn, 0);
        checkVal("idle_valid", oValid, 0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    iRst   = 1'b0;
    iStart = 1'b0;
    iReady = 1'b0;
    curTest = "T1";
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("rst_valid", oValid, 0);
      checkVal("rst_rden", oRdEn, 0);
      checkVal("rst_busy", oBusy, 0);
      checkVal("rst_done", oDone, 0);
      checkVal("rst_addr", oRdAddr, 0);
      iStart = 1'($urandom_range(1));
      iReady = 1'($urandom_range(1));
    end
    @(negedge clk);
    iRst   = 1'b1;
    iStart = 1'b0;
    @(negedge clk);
    checkVal("idle_busy", oBusy, 0);

    runStrip("T2", 100, 1'b0, -1);
    runStrip("T3", 50, 1'b0, -1);
    runStrip("T4", 80, 1'b1, -1);
    runStrip("T5a", 100, 1'b0, 1000);
    runStrip("T5b", 100, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
